// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared definitions for the DSP48A1 multiply-accumulate sequencer.
// Holds OPMODE tokens, FSM state encoding, the per-term token struct
// (opmode and C bias travel together through the skew pipe), and
// parameter defaults matching the slice build (A1/B1/M/P registered,
// OPMODE/C registered).
package dsp_mac_sequencer_pkg;

  localparam int PIPE_LAT_DEF = 3;   // operand issue -> P visible
  localparam int OP_DELAY_DEF = 1;   // opmode/C lag behind their operands
  localparam int CNT_W_DEF    = 11;  // term counter width

  // OPMODE[3:2] = Z mux, OPMODE[1:0] = X mux; upper nibble stays zero
  // (add, carry-in 0, no pre-adder).
  localparam logic [7:0] OP_CLR    = 8'h00;  // X=0, Z=0 : clears P
  localparam logic [7:0] OP_M_ONLY = 8'h01;  // X=M, Z=0 : first term, no bias
  localparam logic [7:0] OP_HOLD   = 8'h08;  // X=0, Z=P : hold P
  localparam logic [7:0] OP_M_P    = 8'h09;  // X=M, Z=P : accumulate
  localparam logic [7:0] OP_M_C    = 8'h0D;  // X=M, Z=C : first term plus bias

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0]  opmode;
    logic [47:0] c;
  } slice_tok_t;

  // All-zero token: clears P and drives C to zero.
  localparam slice_tok_t TOK_CLR  = '{opmode: OP_CLR,  c: 48'd0};
  localparam slice_tok_t TOK_HOLD = '{opmode: OP_HOLD, c: 48'd0};

  // Token for a term that is actually entering the multiplier.
  function automatic slice_tok_t term_token(input logic        first,
                                            input logic        bias_en,
                                            input logic [47:0] bias);
    slice_tok_t tok;
    tok.c = '0;
    if (!first) begin
      tok.opmode = OP_M_P;
    end else if (bias_en) begin
      tok.opmode = OP_M_C;
      tok.c      = bias;
    end else begin
      tok.opmode = OP_M_ONLY;
    end
    return tok;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand stream and result stream between the sequencer and its
// controller (FIR / dot-product control).
//   s_*   : operand pairs, valid/ready, s_last closes an accumulation;
//           bias/bias_en are sampled with the first pair.
//   m_*   : single result, valid/ready, with final carry and term count.
// Modports: master = controller side, slave = sequencer side.
interface dsp_mac_sequencer_if
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             s_valid;
  logic             s_ready;
  logic [17:0]      s_a;
  logic [17:0]      s_b;
  logic             s_last;
  logic [47:0]      bias;
  logic             bias_en;

  logic             m_valid;
  logic             m_ready;
  logic [47:0]      m_data;
  logic             m_carry;
  logic [CNT_W-1:0] m_count;

  modport master (
    output s_valid, s_a, s_b, s_last, bias, bias_en, m_ready,
    input  s_ready, m_valid, m_data, m_carry, m_count
  );

  modport slave (
    input  s_valid, s_a, s_b, s_last, bias, bias_en, m_ready,
    output s_ready, m_valid, m_data, m_carry, m_count
  );

endinterface

// File: rtl/dsp_mac_sequencer_skew_pipe.sv
// dsp_skew_pipe: fixed-depth delay line used to align per-term
// opmode/C tokens with the slice's operand pipeline.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   din      : token entering the line
//   dout     : token DEPTH cycles later (din itself when DEPTH == 0)
module dsp_skew_pipe #(
  parameter int           DEPTH   = 1,
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_pipe
    logic [W-1:0] stage [DEPTH];

    // NOTE: this delay line is reset on purpose, unlike a data memory:
    // its output drives OPMODE directly, so every stage must hold the
    // clearing token while reset is asserted.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one DSP48A1 slice as a multiply-accumulate
// engine. Operand pairs are registered onto dsp_a/dsp_b when accepted;
// the matching opmode/C token follows OP_DELAY cycles later; the final P
// is captured PIPE_LAT cycles after the last issue into a one-entry
// result buffer.
// Ports:
//   clk, RST      : clock, synchronous active-high reset
//   bus (slave)   : operand stream in, result stream out
//   dsp_a/b/c     : slice A, B, C
//   dsp_opmode    : slice OPMODE
//   dsp_ce        : slice CE (constant 1)
//   dsp_rst       : slice RST (follows RST)
//   dsp_p         : slice P
//   dsp_carryout  : slice CARRYOUT
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int OP_DELAY = OP_DELAY_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                RST,
  dsp_mac_sequencer_if.slave  bus,
  output logic [17:0]         dsp_a,
  output logic [17:0]         dsp_b,
  output logic [47:0]         dsp_c,
  output logic [7:0]          dsp_opmode,
  output logic                dsp_ce,
  output logic                dsp_rst,
  input  logic [47:0]         dsp_p,
  input  logic                dsp_carryout
);

  localparam int              DW         = $clog2(PIPE_LAT + 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(PIPE_LAT);

  state_e           state, state_nxt;
  logic             fire;
  logic             drain_done;
  logic [DW-1:0]    drain_cnt;    // cycles since the last issue
  logic [CNT_W-1:0] term_cnt;
  slice_tok_t       issue_tok;    // token aligned with dsp_a/dsp_b
  slice_tok_t       slice_tok;    // token aligned with the slice's OPMODE/C regs

  assign fire       = bus.s_valid && bus.s_ready;
  assign drain_done = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

  assign dsp_ce  = 1'b1;
  assign dsp_rst = RST;

  // ---------------------------------------------------------------- FSM
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: each combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fire) state_nxt = bus.s_last ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: if (fire && bus.s_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nxt = ST_OUT;
      ST_OUT:   if (bus.m_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are forced low while RST is held so nothing is
  // accepted or presented during reset. m_valid is never set in IDLE,
  // so IDLE's s_ready = !m_valid reduces to 1.
  always_comb begin
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    if (!RST) begin
      case (state)
        ST_IDLE:  bus.s_ready = 1'b1;
        ST_ACCUM: bus.s_ready = 1'b1;
        ST_OUT:   bus.m_valid = 1'b1;
        default:  ;
      endcase
    end
  end

  // ------------------------------------------------------ issue datapath
  // Operands are flopped on acceptance; the flop output cycle is the issue
  // cycle. Cycles with no accepted pair issue a hold token so bubbles
  // leave P untouched.
  always_ff @(posedge clk) begin
    if (RST) begin
      dsp_a     <= '0;
      dsp_b     <= '0;
      issue_tok <= TOK_CLR;
      term_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      issue_tok <= TOK_HOLD;
      if (fire) begin
        dsp_a     <= bus.s_a;
        dsp_b     <= bus.s_b;
        drain_cnt <= '0;
        if (state == ST_IDLE) begin
          issue_tok <= term_token(1'b1, bus.bias_en, bus.bias);
          term_cnt  <= CNT_W'(1);
        end else begin
          issue_tok <= term_token(1'b0, 1'b0, 48'd0);
          if (term_cnt != '1) term_cnt <= term_cnt + 1'b1;
        end
      end else if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

  dsp_skew_pipe #(
    .DEPTH   (OP_DELAY),
    .W       ($bits(slice_tok_t)),
    .RST_VAL (TOK_CLR)
  ) u_skew (
    .clk  (clk),
    .rst  (RST),
    .din  (issue_tok),
    .dout (slice_tok)
  );

  assign dsp_opmode = slice_tok.opmode;
  assign dsp_c      = slice_tok.c;

  // ------------------------------------------------------ result buffer
  // Captured in the cycle the slice shows the final sum; held until the
  // next capture regardless of the output handshake.
  always_ff @(posedge clk) begin
    if (RST) begin
      bus.m_data  <= '0;
      bus.m_carry <= 1'b0;
      bus.m_count <= '0;
    end else if (drain_done) begin
      bus.m_data  <= dsp_p;
      bus.m_carry <= dsp_carryout;
      bus.m_count <= term_cnt;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer. A behavioural DSP48A1 slice
// closes the loop; expected results come from plain modular arithmetic
// over the operand list, and the expected OPMODE trace from the rule
// "token one cycle after issue, hold otherwise".
module tb_dsp_mac_sequencer;

  localparam int PIPE_LAT = 3;
  localparam int OP_DELAY = 1;
  localparam int CNT_W    = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [17:0] dsp_a, dsp_b;
  logic [47:0] dsp_c, dsp_p;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce, dsp_rst, dsp_carryout;

  dsp_mac_sequencer_if #(.CNT_W(CNT_W)) bus ();

  dsp_mac_sequencer #(
    .PIPE_LAT (PIPE_LAT),
    .OP_DELAY (OP_DELAY),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .RST          (rst),
    .bus          (bus.slave),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_c        (dsp_c),
    .dsp_opmode   (dsp_opmode),
    .dsp_ce       (dsp_ce),
    .dsp_rst      (dsp_rst),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout)
  );

  // ---------------------------------------------- behavioural slice
  // A1REG=B1REG=MREG=PREG=1, OPMODEREG=CREG=1, synchronous reset.
  logic [17:0] sl_a1, sl_b1;
  logic [35:0] sl_m;
  logic [47:0] sl_c, sl_x, sl_z;
  logic [7:0]  sl_op;

  always_comb begin
    sl_x = '0;
    sl_z = '0;
    if (sl_op[1:0] == 2'b01) sl_x = {12'd0, sl_m};
    case (sl_op[3:2])
      2'b10:   sl_z = dsp_p;
      2'b11:   sl_z = sl_c;
      default: sl_z = '0;
    endcase
  end

  always @(posedge clk) begin
    if (dsp_rst) begin
      sl_a1 <= '0; sl_b1 <= '0; sl_m <= '0; sl_c <= '0; sl_op <= '0;
      dsp_p <= '0; dsp_carryout <= 1'b0;
    end else if (dsp_ce) begin
      sl_a1 <= dsp_a;
      sl_b1 <= dsp_b;
      sl_m  <= sl_a1 * sl_b1;
      sl_c  <= dsp_c;
      sl_op <= dsp_opmode;
      {dsp_carryout, dsp_p} <= {1'b0, sl_z} + {1'b0, sl_x};
    end
  end

  // ---------------------------------------------- bookkeeping
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stream under test and its trace.
  logic [17:0] st_a [$];
  logic [17:0] st_b [$];
  int          st_gap [$];
  int          fire_cyc [$];
  logic [7:0]  tr_op [$];
  logic [47:0] tr_c [$];
  int          tr_cyc [$];
  bit          trace_on = 1'b0;

  logic [47:0]      r_data;
  logic             r_carry;
  logic [CNT_W-1:0] r_count;

  always @(negedge clk) begin
    if (trace_on) begin
      tr_op.push_back(dsp_opmode);
      tr_c.push_back(dsp_c);
      tr_cyc.push_back(cyc);
    end
  end

  // Reference: bias plus sum of products modulo 2^48; carry is that of
  // the last addition only; term count saturates at all-ones.
  function automatic void model(input logic [47:0] bias, input logic bias_en,
                                output logic [47:0] sum, output logic carry,
                                output logic [CNT_W-1:0] cnt);
    logic [48:0] acc;
    logic [47:0] prod;
    acc = bias_en ? {1'b0, bias} : 49'd0;
    for (int i = 0; i < st_a.size(); i++) begin
      prod = st_a[i];
      prod = prod * st_b[i];
      acc  = {1'b0, acc[47:0]} + {1'b0, prod};
    end
    sum   = acc[47:0];
    carry = acc[48];
    cnt   = (st_a.size() >= (1 << CNT_W)) ? '1 : CNT_W'(st_a.size());
  endfunction

  task automatic clear_stream();
    st_a.delete(); st_b.delete(); st_gap.delete();
  endtask

  task automatic add_term(input logic [17:0] a, input logic [17:0] b, input int gap);
    st_a.push_back(a); st_b.push_back(b); st_gap.push_back(gap);
  endtask

  // Present one pair and wait (bounded) for it to be accepted.
  // Called and returns #1 after a rising edge.
  task automatic push(input logic [17:0] a, input logic [17:0] b, input logic last,
                      input logic [47:0] bias, input logic bias_en, output bit ok);
    int waited;
    waited      = 0;
    ok          = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_last  = last;
    bus.bias    = bias;
    bus.bias_en = bias_en;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (bus.s_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check("s_ready_timeout", 64'd0, 64'd1);
      bus.s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    fire_cyc.push_back(cyc);
    check("issue_a", dsp_a, a);
    check("issue_b", dsp_b, b);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic run_stream(input string name, input logic [47:0] bias,
                            input logic bias_en, input int hold);
    logic [47:0]      e_sum;
    logic             e_carry;
    logic [CNT_W-1:0] e_cnt;
    logic [7:0]       e_op;
    bit               ok, got;
    int               n, waited, fi;
    model(bias, bias_en, e_sum, e_carry, e_cnt);
    r_data = 'x; r_carry = 'x; r_count = 'x;
    fire_cyc.delete(); tr_op.delete(); tr_c.delete(); tr_cyc.delete();
    bus.m_ready = (hold == 0);
    trace_on    = 1'b1;
    n = st_a.size();
    for (int i = 0; i < n; i++) begin
      push(st_a[i], st_b[i], (i == n - 1), bias, bias_en, ok);
      if (!ok) begin trace_on = 1'b0; return; end
      if (i != n - 1) repeat (st_gap[i]) begin @(posedge clk); #1; end
    end
    // Drain: no acceptance until the result has been handed over.
    got = 1'b0; waited = 0;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (bus.m_valid) got = 1'b1;
      else begin check({name, ".s_ready_drain"}, bus.s_ready, 1'b0); waited++; end
    end
    if (!got) begin
      check({name, ".m_valid_timeout"}, 64'd0, 64'd1);
      trace_on    = 1'b0;
      bus.m_ready = 1'b1;
      return;
    end
    check({name, ".latency"}, 64'(cyc - fire_cyc[$]), 64'(PIPE_LAT + 1));
    check({name, ".data"},  bus.m_data,  e_sum);
    check({name, ".carry"}, bus.m_carry, e_carry);
    check({name, ".count"}, bus.m_count, e_cnt);
    r_data = bus.m_data; r_carry = bus.m_carry; r_count = bus.m_count;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, ".hold_valid"}, bus.m_valid, 1'b1);
      check({name, ".hold_data"},  bus.m_data,  e_sum);
      check({name, ".hold_ready"}, bus.s_ready, 1'b0);
    end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    trace_on = 1'b0;
    check({name, ".valid_clear"}, bus.m_valid, 1'b0);
    check({name, ".ready_again"}, bus.s_ready, 1'b1);
    // OPMODE trace from one cycle after the first issue to the result.
    fi = 0;
    for (int j = 0; j < tr_op.size(); j++) begin
      if (tr_cyc[j] <= fire_cyc[0]) continue;
      while (fi < fire_cyc.size() && fire_cyc[fi] + 1 < tr_cyc[j]) fi++;
      if (fi < fire_cyc.size() && fire_cyc[fi] + 1 == tr_cyc[j])
        e_op = (fi != 0) ? 8'h09 : (bias_en ? 8'h0D : 8'h01);
      else
        e_op = 8'h08;
      check({name, ".opmode"}, tr_op[j], e_op);
      if (e_op == 8'h0D) check({name, ".c"}, tr_c[j], bias);
    end
  endtask

  function automatic logic [17:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 18'h3FFFF;
      1:       return 18'(($urandom_range(0, 15)));
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0;
    bus.bias = '0; bus.bias_en = 1'b0; bus.m_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Reset state
    check("rst.s_ready", bus.s_ready, 1'b0);
    check("rst.m_valid", bus.m_valid, 1'b0);
    check("rst.m_data",  bus.m_data,  48'd0);
    check("rst.m_carry", bus.m_carry, 1'b0);
    check("rst.m_count", bus.m_count, 11'd0);
    check("rst.dsp_a",   dsp_a, 18'd0);
    check("rst.dsp_b",   dsp_b, 18'd0);
    check("rst.dsp_c",   dsp_c, 48'd0);
    check("rst.opmode",  dsp_opmode, 8'h00);
    check("rst.ce",      dsp_ce, 1'b1);
    check("rst.dsp_rst", dsp_rst, 1'b1);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle.opmode", dsp_opmode, 8'h08);
    check("idle.dsp_rst", dsp_rst, 1'b0);

    // Single term
    clear_stream(); add_term(18'd3, 18'd4, 0);
    run_stream("t1", 48'd0, 1'b0, 0);
    check("t1.lit_data", r_data, 48'd12);
    check("t1.lit_count", r_count, 11'd1);

    // Four terms with bias
    clear_stream();
    add_term(18'd1, 18'd2, 0); add_term(18'd3, 18'd4, 0);
    add_term(18'd5, 18'd6, 0); add_term(18'd7, 18'd8, 0);
    run_stream("t2", 48'd100, 1'b1, 0);
    check("t2.lit_data", r_data, 48'd200);
    check("t2.lit_count", r_count, 11'd4);

    // Same terms with bubbles, no bias
    clear_stream();
    add_term(18'd1, 18'd2, 1); add_term(18'd3, 18'd4, 3);
    add_term(18'd5, 18'd6, 0); add_term(18'd7, 18'd8, 0);
    run_stream("t3", 48'd0, 1'b0, 0);
    check("t3.lit_data", r_data, 48'd100);
    check("t3.lit_count", r_count, 11'd4);

    // Wrap-around: bias overflow happens on the first add, not the last
    clear_stream();
    add_term(18'h3FFFF, 18'h3FFFF, 0); add_term(18'h3FFFF, 18'h3FFFF, 0);
    run_stream("t4", 48'hFFFF_FFFF_FFFF, 1'b1, 0);
    check("t4.lit_data", r_data, 48'h001F_FFF0_0001);
    check("t4.lit_carry", r_carry, 1'b0);

    // Final addition carries out
    clear_stream();
    add_term(18'd1, 18'd1, 0); add_term(18'h3FFFF, 18'h3FFFF, 0);
    run_stream("t4b", 48'hFFFF_FFFF_FFF0, 1'b1, 0);
    check("t4b.lit_data", r_data, 48'h000F_FFF7_FFF2);
    check("t4b.lit_carry", r_carry, 1'b1);

    // Consumer stalls for 10 cycles
    clear_stream();
    add_term(18'd1, 18'd2, 0); add_term(18'd3, 18'd4, 0);
    add_term(18'd5, 18'd6, 0); add_term(18'd7, 18'd8, 0);
    run_stream("t5", 48'd100, 1'b1, 10);
    check("t5.lit_data", r_data, 48'd200);

    // Reset after two of four terms
    fire_cyc.delete();
    push(18'd9, 18'd9, 1'b0, 48'd7, 1'b1, ok);
    push(18'd8, 18'd8, 1'b0, 48'd7, 1'b1, ok);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6.rst_opmode", dsp_opmode, 8'h00);
    check("t6.rst_valid",  bus.m_valid, 1'b0);
    check("t6.rst_ready",  bus.s_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t6.no_result", bus.m_valid, 1'b0);
    end
    @(posedge clk); #1;
    clear_stream(); add_term(18'd2, 18'd5, 0);
    run_stream("t6", 48'd0, 1'b0, 0);
    check("t6.lit_data", r_data, 48'd10);

    // Randomised streams
    for (int s = 0; s < 25; s++) begin
      int n_terms;
      clear_stream();
      n_terms = $urandom_range(1, 6);
      for (int i = 0; i < n_terms; i++)
        add_term(rand_operand(), rand_operand(), $urandom_range(0, 3));
      run_stream($sformatf("r%0d", s), {16'($urandom), 32'($urandom)},
                 1'($urandom), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Term counter saturation
    clear_stream();
    for (int i = 0; i < 2050; i++) add_term(18'($urandom_range(0, 255)), 18'($urandom_range(0, 255)), 0);
    run_stream("sat", 48'd0, 1'b0, 0);
    check("sat.lit_count", r_count, 11'h7FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
